unidade_controle_multiciclo: RTL and testbench

//  Multi-cycle control FSM for the 8-bit processor. Sequences fetch/decode/execute.

---
 rtl/unidade_controle_multiciclo_if.sv | 34 +++
 rtl/unidade_controle_multiciclo.sv | 154 +++++++++++++++
 tb/tb_unidade_controle_multiciclo.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/unidade_controle_multiciclo_if.sv
// Signal bundle between the multi-cycle control unit (master) and the
// datapath/memory side (slave).
interface unidade_controle_multiciclo_if;
   logic [2:0] Opcode;
   logic       Zero;
   logic       MemPronto;
   logic       MemReq;
   logic       MemEscrita;
   logic       SelEndereco;
   logic       IREscrita;
   logic       PCEscrita;
   logic [1:0] SelPC;
   logic       SelUlaB;
   logic       SelDadoReg;
   logic       RegEscrita;
   logic       Parado;
   logic       ErroMem;
   logic [2:0] Estado;

   // Handshake: MemReq stays high with stable MemEscrita/SelEndereco until the
   // cycle in which MemPronto is high; that cycle completes the transfer.
   // MemPronto while MemReq is low carries no meaning.
   modport master (
      input  Opcode, Zero, MemPronto,
      output MemReq, MemEscrita, SelEndereco, IREscrita, PCEscrita, SelPC,
             SelUlaB, SelDadoReg, RegEscrita, Parado, ErroMem, Estado
   );

   modport slave (
      output Opcode, Zero, MemPronto,
      input  MemReq, MemEscrita, SelEndereco, IREscrita, PCEscrita, SelPC,
             SelUlaB, SelDadoReg, RegEscrita, Parado, ErroMem, Estado
   );
endinterface

// File: rtl/unidade_controle_multiciclo.sv
// Multi-cycle control FSM (fetch/decode/execute) for the 8-bit processor.
// Optional retired-instruction counter enabled by defining CONTADOR_INSTRUCOES_EN.
module unidade_controle_multiciclo #(
   parameter int LARGURA_CONTADOR = 16,
   parameter int ESPERA_MAX       = 0
) (
   input logic                         Clock,
   input logic                         Reset,
   unidade_controle_multiciclo_if.master bus
`ifdef CONTADOR_INSTRUCOES_EN
   ,
   output logic [LARGURA_CONTADOR-1:0] InstrucoesExecutadas
`endif
);

   localparam logic [2:0] BUSCA   = 3'd0;
   localparam logic [2:0] DECOD   = 3'd1;
   localparam logic [2:0] EXEC    = 3'd2;
   localparam logic [2:0] MEM     = 3'd3;
   localparam logic [2:0] ESCRITA = 3'd4;
   localparam logic [2:0] PARADO  = 3'd5;

   localparam logic [2:0] OP_ADDI  = 3'd0;
   localparam logic [2:0] OP_LOAD  = 3'd1;
   localparam logic [2:0] OP_STORE = 3'd2;
   localparam logic [2:0] OP_BEQZ  = 3'd3;
   localparam logic [2:0] OP_JMP   = 3'd4;
   localparam logic [2:0] OP_ADD   = 3'd5;
   localparam logic [2:0] OP_NOP   = 3'd6;
   localparam logic [2:0] OP_HALT  = 3'd7;

   localparam int EW = (ESPERA_MAX > 1) ? $clog2(ESPERA_MAX) : 1;

   logic [2:0]    estado, prox;
   logic [2:0]    op_q;
   logic [EW-1:0] espera;
   logic          erro_q;
   logic          esperando;
   logic          estouro;

   assign esperando = ((estado == BUSCA) || (estado == MEM)) && !bus.MemPronto;
   // Timeout fires in the last allowed waiting cycle so PARADO is reached
   // exactly ESPERA_MAX cycles after entering the wait.
   assign estouro = (ESPERA_MAX > 0) && esperando && (espera == EW'(ESPERA_MAX - 1));

   always_comb begin
      prox             = estado;
      bus.MemReq       = 1'b0;
      bus.MemEscrita   = 1'b0;
      bus.SelEndereco  = 1'b0;
      bus.IREscrita    = 1'b0;
      bus.PCEscrita    = 1'b0;
      bus.SelPC        = 2'b00;
      bus.SelUlaB      = 1'b0;
      bus.SelDadoReg   = 1'b0;
      bus.RegEscrita   = 1'b0;
      case (estado)
         BUSCA: begin
            bus.MemReq = 1'b1;
            if (bus.MemPronto) begin
               bus.IREscrita = 1'b1;
               bus.PCEscrita = 1'b1;
               prox          = DECOD;
            end else if (estouro) begin
               prox = PARADO;
            end
         end
         DECOD: begin
            case (bus.Opcode)
               OP_LOAD, OP_STORE: prox = MEM;
               OP_NOP:            prox = BUSCA;
               OP_HALT:           prox = PARADO;
               default:           prox = EXEC;
            endcase
         end
         EXEC: begin
            prox = BUSCA;
            case (op_q)
               OP_ADDI: begin
                  bus.SelUlaB    = 1'b1;
                  bus.RegEscrita = 1'b1;
               end
               OP_ADD:  bus.RegEscrita = 1'b1;
               OP_BEQZ: begin
                  bus.SelPC     = 2'b01;
                  bus.PCEscrita = bus.Zero;
               end
               OP_JMP: begin
                  bus.SelPC     = 2'b10;
                  bus.PCEscrita = 1'b1;
               end
               default: ;
            endcase
         end
         MEM: begin
            bus.MemReq      = 1'b1;
            bus.SelEndereco = 1'b1;
            bus.MemEscrita  = (op_q == OP_STORE);
            if (bus.MemPronto) begin
               prox = (op_q == OP_LOAD) ? ESCRITA : BUSCA;
            end else if (estouro) begin
               prox = PARADO;
            end
         end
         ESCRITA: begin
            bus.SelDadoReg = 1'b1;
            bus.RegEscrita = 1'b1;
            prox           = BUSCA;
         end
         PARADO:  prox = PARADO;
         default: prox = BUSCA;
      endcase
      // Reset aborts any in-flight request before the edge can commit it.
      if (Reset) begin
         bus.MemReq     = 1'b0;
         bus.MemEscrita = 1'b0;
         bus.IREscrita  = 1'b0;
         bus.PCEscrita  = 1'b0;
         bus.RegEscrita = 1'b0;
      end
   end

   assign bus.Parado  = (estado == PARADO);
   assign bus.ErroMem = erro_q;
   assign bus.Estado  = estado;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         estado <= BUSCA;
         op_q   <= OP_ADDI;
         espera <= '0;
         erro_q <= 1'b0;
      end else begin
         estado <= prox;
         if (estado == DECOD) op_q <= bus.Opcode;
         espera <= esperando ? espera + 1'b1 : '0;
         if (estouro) erro_q <= 1'b1;
      end
   end

`ifdef CONTADOR_INSTRUCOES_EN
   logic fim_instr;

   assign fim_instr = ((prox == BUSCA) && ((estado == DECOD) || (estado == EXEC) ||
                                           (estado == MEM) || (estado == ESCRITA)))
                    || ((estado == DECOD) && (prox == PARADO));

   always_ff @(posedge Clock) begin
      if (Reset)          InstrucoesExecutadas <= '0;
      else if (fim_instr) InstrucoesExecutadas <= InstrucoesExecutadas + 1'b1;
   end
`endif

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Bench for unidade_controle_multiciclo: per-instruction cycle expectations built
// from the instruction semantics, plus a timeout instance with ESPERA_MAX=4.
module tb_unidade_controle_multiciclo;

   localparam logic [2:0] OP_LOAD  = 3'd1;
   localparam logic [2:0] OP_STORE = 3'd2;
   localparam logic [2:0] OP_BEQZ  = 3'd3;
   localparam logic [2:0] OP_JMP   = 3'd4;
   localparam logic [2:0] OP_ADD   = 3'd5;
   localparam logic [2:0] OP_NOP   = 3'd6;
   localparam logic [2:0] OP_HALT  = 3'd7;

   typedef struct packed {
      logic [2:0] est;
      logic       memreq, memesc, selend, irw, pcw;
      logic [1:0] selpc;
      logic       selb, seldado, regw, parado, erro;
   } outs_t;

   typedef struct packed {
      logic  mp;
      outs_t o;
   } cyc_t;

   logic Clock = 1'b0;
   logic Reset;
   logic rst2;

   always #5 Clock = ~Clock;

   unidade_controle_multiciclo_if bus ();
   unidade_controle_multiciclo_if bus2 ();

`ifdef CONTADOR_INSTRUCOES_EN
   logic [15:0] cnt1, cnt2;
`endif

   unidade_controle_multiciclo #(.LARGURA_CONTADOR(16), .ESPERA_MAX(0)) dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus)
`ifdef CONTADOR_INSTRUCOES_EN
      , .InstrucoesExecutadas (cnt1)
`endif
   );

   unidade_controle_multiciclo #(.LARGURA_CONTADOR(16), .ESPERA_MAX(4)) dut_espera (
      .Clock (Clock),
      .Reset (rst2),
      .bus   (bus2)
`ifdef CONTADOR_INSTRUCOES_EN
      , .InstrucoesExecutadas (cnt2)
`endif
   );

   cyc_t  exp_q[$];
   int    checks = 0;
   int    errors = 0;
   logic  erro_exp = 1'b0;
   int    cnt_exp = 0;
   string cur_tag = "none";
   outs_t obs, obs2;

   assign obs  = {bus.Estado, bus.MemReq, bus.MemEscrita, bus.SelEndereco, bus.IREscrita,
                  bus.PCEscrita, bus.SelPC, bus.SelUlaB, bus.SelDadoReg, bus.RegEscrita,
                  bus.Parado, bus.ErroMem};
   assign obs2 = {bus2.Estado, bus2.MemReq, bus2.MemEscrita, bus2.SelEndereco, bus2.IREscrita,
                  bus2.PCEscrita, bus2.SelPC, bus2.SelUlaB, bus2.SelDadoReg, bus2.RegEscrita,
                  bus2.Parado, bus2.ErroMem};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
      checks++;
      assert (got === expv) else begin
         errors++;
         $error("FAIL %s got %h exp %h", tag, got, expv);
      end
   endtask

   function automatic outs_t st(input logic [2:0] e);
      outs_t o;
      o        = '0;
      o.est    = e;
      o.parado = (e == 3'd5);
      o.erro   = erro_exp;
      return o;
   endfunction

   function automatic logic rmp();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic push(input logic mp, input outs_t o);
      cyc_t c;
      c.mp = mp;
      c.o  = o;
      exp_q.push_back(c);
   endtask

   // Fetch: df stalled cycles, then the completing cycle loads IR and PC+1.
   task automatic model_fetch(input int df);
      outs_t o;
      for (int i = 0; i < df; i++) begin
         o = st(3'd0); o.memreq = 1'b1;
         push(1'b0, o);
      end
      o = st(3'd0); o.memreq = 1'b1; o.irw = 1'b1; o.pcw = 1'b1;
      push(1'b1, o);
   endtask

   // Decode plus the op-specific tail; non-request cycles drive random MemPronto.
   task automatic model_body(input logic [2:0] op, input logic z, input int dm);
      outs_t o;
      push(rmp(), st(3'd1));
      case (op)
         OP_LOAD, OP_STORE: begin
            for (int i = 0; i <= dm; i++) begin
               o = st(3'd3); o.memreq = 1'b1; o.selend = 1'b1; o.memesc = (op == OP_STORE);
               push(i == dm, o);
            end
            if (op == OP_LOAD) begin
               o = st(3'd4); o.seldado = 1'b1; o.regw = 1'b1;
               push(rmp(), o);
            end
         end
         OP_NOP: ;
         OP_HALT: for (int i = 0; i < 3; i++) push(rmp(), st(3'd5));
         OP_BEQZ: begin
            o = st(3'd2); o.selpc = 2'b01; o.pcw = z;
            push(rmp(), o);
         end
         OP_JMP: begin
            o = st(3'd2); o.selpc = 2'b10; o.pcw = 1'b1;
            push(rmp(), o);
         end
         OP_ADD: begin
            o = st(3'd2); o.regw = 1'b1;
            push(rmp(), o);
         end
         default: begin
            o = st(3'd2); o.selb = 1'b1; o.regw = 1'b1;
            push(rmp(), o);
         end
      endcase
      cnt_exp++;
   endtask

   task automatic run_queue();
      cyc_t c;
      while (exp_q.size() > 0) begin
         c = exp_q.pop_front();
         bus.MemPronto = c.mp;
         @(negedge Clock);
         check(cur_tag, 32'(obs), 32'(c.o));
         @(posedge Clock);
         #1;
      end
   endtask

   task automatic do_reset();
      outs_t o;
      Reset = 1'b1;
      bus.MemPronto = 1'b1;
      @(negedge Clock);
      check("reset_strobes", 32'({bus.MemReq, bus.MemEscrita, bus.IREscrita, bus.PCEscrita,
                                  bus.RegEscrita}), 32'(0));
      @(posedge Clock);
      #1;
      Reset = 1'b0;
      bus.MemPronto = 1'b0;
      erro_exp = 1'b0;
      cnt_exp = 0;
      @(negedge Clock);
      o = st(3'd0); o.memreq = 1'b1;
      check("reset_state", 32'(obs), 32'(o));
      @(posedge Clock);
      #1;
   endtask

   task automatic instr(input logic [7:0] ins, input logic z, input int df, input int dm);
      cur_tag    = $sformatf("instr_%02h_z%0d_f%0d_m%0d", ins, z, df, dm);
      bus.Opcode = ins[7:5];
      bus.Zero   = z;
      model_fetch(df);
      model_body(ins[7:5], z, dm);
      run_queue();
`ifdef CONTADOR_INSTRUCOES_EN
      check("count", 32'(cnt1), 32'(16'(cnt_exp)));
`endif
      if (ins[7:5] == OP_HALT) do_reset();
   endtask

   initial begin
      logic [7:0] ins;
      Reset          = 1'b1;
      rst2           = 1'b1;
      bus.Opcode     = 3'd0;
      bus.Zero       = 1'b0;
      bus.MemPronto  = 1'b0;
      bus2.Opcode    = 3'd0;
      bus2.Zero      = 1'b0;
      bus2.MemPronto = 1'b0;
      @(posedge Clock);
      #1;
      do_reset();

      instr(8'h03, 1'b0, 0, 0);
      instr(8'h3F, 1'b0, 0, 2);
      instr(8'h7E, 1'b0, 0, 0);
      instr(8'h7E, 1'b1, 1, 0);
      instr(8'h85, 1'b0, 0, 0);
      instr(8'hA1, 1'b1, 2, 0);
      instr(8'hC0, 1'b0, 0, 0);
      instr(8'h41, 1'b0, 1, 3);
      instr(8'hE0, 1'b0, 0, 0);

      // Reset in MEM of a STORE while memory answers: nothing may be written.
      cur_tag    = "store_reset";
      bus.Opcode = OP_STORE;
      bus.Zero   = 1'b0;
      model_fetch(0);
      push(rmp(), st(3'd1));
      run_queue();
      Reset = 1'b1;
      bus.MemPronto = 1'b1;
      @(negedge Clock);
      check("mem_reset_strobes", 32'({bus.Estado, bus.MemReq, bus.MemEscrita, bus.IREscrita,
                                      bus.PCEscrita, bus.RegEscrita}), 32'({3'd3, 5'b0}));
      @(posedge Clock);
      #1;
      Reset = 1'b0;
      bus.MemPronto = 1'b0;
      cnt_exp = 0;
      @(negedge Clock);
      check("mem_reset_state", 32'(bus.Estado), 32'(0));
      @(posedge Clock);
      #1;

      for (int i = 0; i < 60; i++) begin
         ins = 8'($urandom);
         instr(ins, rmp(), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end

      // Timeout instance: memory never answers the fetch.
      rst2 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge Clock);
         check($sformatf("espera_busca_%0d", i), 32'({bus2.Estado, bus2.MemReq, bus2.ErroMem}),
               32'({3'd0, 1'b1, 1'b0}));
         @(posedge Clock);
         #1;
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge Clock);
         check($sformatf("espera_parado_%0d", i), 32'(obs2), 32'({3'd5, 10'b0, 1'b1, 1'b1}));
         @(posedge Clock);
         #1;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
